gf3_vec_scale_acc: RTL
======================

Name: gf3_vec_scale_acc

Overview:
- Multi-cycle, lane-serial GF(3)^M vector scale/accumulate unit for the Tate-pairing datapath.
- Multiplies a GF(3^M) element (trit vector) by a GF(3) scalar and either writes the product or adds/subtracts it into an internal accumulator.
- Processes LANES trits per cycle, trading area for latency, under a start/done handshake that matches the other multi-cycle arithmetic units.

Parameters:
- M, 97, number of trits per element; vector width is 2*M bits.
- LANES, 8, trits processed per cycle; legal range 1..M.
- BEATS, derived as ceil(M/LANES), number of RUN cycles per operation (13 at defaults); not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- op  in  2  00 = scale (acc = A*aa), 01 = add (acc = acc + A*aa), 10 = sub (acc = acc - A*aa), 11 = clear (acc = 0).
- A  in  2*M  operand vector; trit i occupies bits [2i+1:2i].
- aa  in  2  GF(3) scalar.
- C  out  2*M  accumulator contents.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when C holds the final result.

Behaviour:
- Trit encoding: 00=0, 01=1, 10=2. Code 11 is invalid and is treated as 0 on A and aa (product 0). No output trit is ever 11.
- GF(3) multiply: 1*1=1, 1*2=2, 2*2=1, anything*0=0.
- GF(3) add: sum mod 3.
- GF(3) sub: acc + 2*(A*aa) mod 3.
- Reset (reset_n low, asynchronous):
  - state=IDLE, C=0, busy=0, done=0, beat counter=0, captured operands=0.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, CLR.
- IDLE:
  - On a rising edge with start=1: capture A, aa and op into internal registers, set busy=1 and clear the beat counter.
  - Next state is CLR if op=11, otherwise RUN.
  - C is unchanged by the capture edge.
  - With start=0, C holds its value.
- RUN:
  - Beat b (0..BEATS-1) updates trits [b*LANES, b*LANES+LANES-1] of C from the captured operands only.
  - Trit indices >= M in the final beat are ignored; partial last beat is legal.
  - Trits outside the current slice hold their values.
  - On the edge completing beat BEATS-1: done=1 for the following cycle, busy=0, state=IDLE.
- CLR: the next edge sets C=0, done=1, busy=0, state=IDLE (latency 1 regardless of BEATS).
- Latency for scale/add/sub:
  - start sampled at edge 0; slices written at edges 1..BEATS.
  - done is high in the cycle after edge BEATS, i.e. BEATS+1 cycles after start is sampled.
- C is valid only when busy=0; intermediate slice values are visible but undefined for consumers.
- Start while busy: ignored, with no queuing. A, aa and op may change freely after the capture edge.
- The done cycle is also IDLE. start=1 in that cycle launches a new operation (back-to-back, no bubble); done and the new busy coincide for that one cycle.
- Single-ported accumulator: add/sub use the C value left by the previous operation.

Test Plan:
- M=5, LANES=2 (BEATS=3), reset, then op=00, A=trits{1,2,0,1,2}, aa=2 -> busy high 3 cycles; done pulses at start+4 cycles; C=trits{2,1,0,2,1}.
- Same config, C={2,1,0,2,1}, then op=01, A={1,1,1,1,1}, aa=1 -> C={0,2,1,0,2}. Follow with op=10 and the same A/aa -> C returns to {2,1,0,2,1}.
- Defaults (M=97, LANES=8): op=00, A = all trits 1, aa=1 -> done exactly 14 cycles after start; C = all trits 1. Trit 96 is written on beat 12 and no out-of-range write occurs. Repeat with aa=0 -> C=0.
- Invalid codes: A trit = 11 and aa=11 in separate runs -> corresponding product trits 00. Confirm no C trit ever equals 11 across 10k random operations against a software GF(3) model.
- Handshake: pulse start during busy with different A -> ignored, result matches the first operands. Assert start in the done cycle -> second op starts immediately, and its done arrives BEATS+1 cycles later.
- op=11 from nonzero C -> C=0 with done one cycle after start. Drop reset_n mid-RUN -> C=0, busy=0 and done=0 immediately; no done pulse after reset release.

Source files
------------

// File: rtl/gf3_vec_scale_acc.sv
// Lane-serial GF(3)^M scale/accumulate unit: C = A*aa, C +/- A*aa, or clear.
// Processes LANES trits per beat under a start/busy/done handshake.
module gf3_vec_scale_acc #(
    parameter int M     = 97,
    parameter int LANES = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [2*M-1:0] A,
    input  logic [1:0]     aa,
    output logic [2*M-1:0] C,
    output logic           busy,
    output logic           done
);

    localparam int BEATS = (M + LANES - 1) / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_CLR  = 2'd2;

    localparam logic [1:0] OP_SCALE = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    logic [1:0]     state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [2*M-1:0] a_q, a_d;
    logic [1:0]     aa_q, aa_d;
    logic [1:0]     op_q, op_d;
    logic [2*M-1:0] c_q, c_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Code 11 is an invalid trit and multiplies as zero.
    function automatic logic [1:0] gf3_mul(input logic [1:0] x,
                                           input logic [1:0] y);
        if (x == 2'b00 || y == 2'b00 || x == 2'b11 || y == 2'b11)
            return 2'b00;
        return (x == y) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] gf3_add(input logic [1:0] x,
                                           input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= 3'd3)
            s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic logic [1:0] gf3_neg(input logic [1:0] x);
        unique case (x)
            2'b01:   return 2'b10;
            2'b10:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    always_comb begin
        logic [1:0] p;
        logic [1:0] t;
        p       = 2'b00;
        t       = 2'b00;
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        aa_d    = aa_q;
        op_d    = op_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    aa_d    = aa;
                    op_d    = op;
                    busy_d  = 1'b1;
                    beat_d  = '0;
                    state_d = (op == OP_CLR) ? S_CLR : S_RUN;
                end
            end
            S_RUN: begin
                // Each trit belongs to exactly one beat; indices >= M never exist.
                for (int i = 0; i < M; i++) begin
                    if (beat_q == BW'(i / LANES)) begin
                        p = gf3_mul(a_q[2*i +: 2], aa_q);
                        t = c_q[2*i +: 2];
                        unique case (op_q)
                            OP_ADD:   c_d[2*i +: 2] = gf3_add(t, p);
                            OP_SUB:   c_d[2*i +: 2] = gf3_add(t, gf3_neg(p));
                            OP_SCALE: c_d[2*i +: 2] = p;
                            default:  c_d[2*i +: 2] = t;
                        endcase
                    end
                end
                if (beat_q == BW'(BEATS - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_CLR: begin
                c_d     = '0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            aa_q    <= '0;
            op_q    <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            aa_q    <= aa_d;
            op_q    <= op_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign C    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
